core_mem_s: RTL and testbench
=============================

# core_mem_s

Memory stage of the Selen core pipeline, directly downstream of the execute stage. Consumes the exe/mem pipeline register, performs L1D load/store transactions through a request/acknowledge handshake, and sign/zero-extends load data. Writes the mem/wb register and raises a stall to the hazard unit while a transaction is outstanding.

## Interface
- No parameters. Encodings, fixed in core_defines.vh:
  - size: 3'b001 byte, 3'b010 half, 3'b100 word.
  - wb_sx_op: 0 SB, 1 SH, 2 W, 3 UB, 4 UH, 5 WB_SX_BP (pass-through).
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- mem_enb  in  1  mem/wb register load enable from the hazard unit.
- mem_kill  in  1  flush of this stage.
- mem_val_inst_in  in  1  valid instruction.
- mem_we_reg_file_in  in  1  register-file write enable.
- mem_wb_sx_op_in  in  3  load extension op.
- mem_mux_alu_mem_in  in  1  result select: 1 = memory data, 0 = ALU result.
- mem_l1d_val_in  in  1  memory access present.
- mem_l1d_cop_in  in  1  access type: 0 = load, 1 = store.
- mem_l1d_size_in  in  3  access size.
- mem_alu_result_in  in  32  ALU result.
- mem_addr_in  in  32  effective address.
- mem_wrt_data_in  in  32  store data, right-aligned.
- mem_rd_in  in  5  destination register.
- l1d_req_val  out  1  request valid.
- l1d_req_cop  out  1  request type.
- l1d_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- l1d_req_wdata  out  32  store data replicated across byte lanes.
- l1d_req_be  out  4  byte enables.
- l1d_req_ack  in  1  request accepted.
- l1d_ack_val  in  1  response valid.
- l1d_ack_rdata  in  32  read word.
- mem_stall_out  out  1  to hazard unit: hold upstream stages.
- mem2haz_result_out  out  32  mem/wb result, for forwarding.
- mem_result_out_reg  out  32  mem/wb register: writeback data.
- mem_rd_out_reg  out  5  mem/wb register: destination register.
- mem_we_reg_file_out_reg  out  1  mem/wb register: write enable.
- mem_val_inst_out_reg  out  1  mem/wb register: valid instruction.
- mem_misalign_out_reg  out  1  mem/wb register: misaligned-access flag.

## Operation
- Access condition: acc = mem_val_inst_in & mem_l1d_val_in & ~misalign.
- Misalign rules: half with addr[0]=1; word with addr[1:0]!=0.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Load lane select:
  - byte: rdata[8*addr[1:0] +: 8].
  - half: rdata[16*addr[1] +: 16].
  - Then extend per wb_sx_op. WB_SX_BP passes the word unchanged.
- FSM states and transitions:
  - IDLE: acc -> REQ.
  - REQ: l1d_req_val=1, outputs held stable; l1d_req_ack -> WAIT.
  - WAIT: l1d_ack_val -> capture extended data in buffer, then DONE if ~mem_enb, else IDLE.
  - DONE: mem_enb -> IDLE.
- mem_stall_out = (IDLE & acc) | REQ | WAIT.
  - Deasserted in the WAIT cycle in which l1d_ack_val=1.
  - Deasserted in DONE.
- mem/wb register loads on mem_enb & ~mem_stall_out.
  - Result source: memory data if mem_mux_alu_mem_in, else mem_alu_result_in.
  - Memory data comes from l1d_ack_rdata in WAIT, or from the buffer in DONE.
  - Stores also wait for l1d_ack_val; their result is don't-care.
  - If mem_enb=1 while mem_stall_out=1, the register still loads, with mem_val_inst_out_reg=0 and mem_we_reg_file_out_reg=0 (bubble).
- Misaligned access:
  - No request is issued and the stage does not stall.
  - The instruction passes with mem_we_reg_file_out_reg=0 and mem_misalign_out_reg=1.
- mem_kill:
  - In IDLE or REQ: FSM -> IDLE, req_val drops; the mem/wb register loads a bubble.
  - In WAIT: a drop flag is set and the stall is held until l1d_ack_val. The response is then discarded (bubble) and the FSM goes to IDLE.
  - In DONE: the buffer is discarded and the FSM goes to IDLE.
  - Kill has priority over mem_enb.
- mem2haz_result_out = mem_result_out_reg.

## Timing
- Reset (synchronous): FSM IDLE, drop flag 0; all registered outputs 0; l1d_req_val=0; mem_stall_out=0.
- Non-memory instruction: 1-cycle latency, no stall.
- Load, with req_ack in its first REQ cycle and ack_val in the first WAIT cycle:
  - Cycle 0: IDLE, stall=1.
  - Cycle 1: REQ.
  - Cycle 2: WAIT with ack, stall=0; the mem/wb register loads at the end of cycle 2.
  - Minimum 3 cycles in the stage.
- Request fields are constant from REQ entry until acknowledged.
- At most one request is outstanding.
- l1d_ack_val outside WAIT is ignored.
- Reset in REQ or WAIT: returns to IDLE immediately. Any late L1D response is ignored.

## Configuration
- CORE_MEM_MISALIGN_CHK_EN defined: misalign detection as above.
- Not defined: misalign=0; the request address is forced word-aligned; mem_misalign_out_reg ties to 0; byte enables and lane select use addr[1:0] unchanged.

## Test plan
- LW, addr 0x100, rdata 0xDEADBEEF, ack next cycle -> stall high 2 cycles; result 0xDEADBEEF, we=1, rd passed through.
- LB signed, addr 0x103, rdata 0x80FFFFFF -> result 0xFFFFFF80; LBU same -> 0x00000080.
- SH, addr 0x102, data 0x1234 -> be=4'b1100, wdata 0x12341234, req_addr 0x100.
- Ack in WAIT with mem_enb=0 for 3 cycles -> FSM in DONE, stall=0; data loads when mem_enb rises.
- mem_kill in WAIT, ack 2 cycles later -> stall held until ack; mem/wb receives a bubble (val=0, we=0).
- With the macro: LW at 0x101 -> no l1d_req_val, misalign=1, we=0. Without the macro: request to 0x100.

Source files
------------

// File: rtl/core_mem_s_if.sv
// core_mem_s_if: L1D request/acknowledge bus between the memory stage (master) and the data cache (slave).
interface core_mem_s_if;
    logic        l1d_req_val;
    logic        l1d_req_cop;
    logic [31:0] l1d_req_addr;
    logic [31:0] l1d_req_wdata;
    logic [3:0]  l1d_req_be;
    logic        l1d_req_ack;
    logic        l1d_ack_val;
    logic [31:0] l1d_ack_rdata;

    modport master (
        output l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        input  l1d_req_ack, l1d_ack_val, l1d_ack_rdata
    );

    modport slave (
        input  l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        output l1d_req_ack, l1d_ack_val, l1d_ack_rdata
    );
endinterface

// File: rtl/core_mem_s.sv
// core_mem_s: Selen memory stage -- L1D load/store handshake, load extension, mem/wb register.
// Optional feature: define CORE_MEM_MISALIGN_CHK_EN to flag misaligned half/word accesses.
module core_mem_s (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_enb,
    input  logic          mem_kill,
    input  logic          mem_val_inst_in,
    input  logic          mem_we_reg_file_in,
    input  logic [2:0]    mem_wb_sx_op_in,
    input  logic          mem_mux_alu_mem_in,
    input  logic          mem_l1d_val_in,
    input  logic          mem_l1d_cop_in,
    input  logic [2:0]    mem_l1d_size_in,
    input  logic [31:0]   mem_alu_result_in,
    input  logic [31:0]   mem_addr_in,
    input  logic [31:0]   mem_wrt_data_in,
    input  logic [4:0]    mem_rd_in,
    core_mem_s_if.master  l1d,
    output logic          mem_stall_out,
    output logic [31:0]   mem2haz_result_out,
    output logic [31:0]   mem_result_out_reg,
    output logic [4:0]    mem_rd_out_reg,
    output logic          mem_we_reg_file_out_reg,
    output logic          mem_val_inst_out_reg,
    output logic          mem_misalign_out_reg
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;

    localparam logic [2:0] SX_SB = 3'd0;
    localparam logic [2:0] SX_SH = 3'd1;
    localparam logic [2:0] SX_W  = 3'd2;
    localparam logic [2:0] SX_UB = 3'd3;
    localparam logic [2:0] SX_UH = 3'd4;
    localparam logic [2:0] SX_BP = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic              req_cop_q, req_cop_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic [3:0]        req_be_q, req_be_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic              we_q, we_d;
    logic              val_q, val_d;
    logic              mis_q, mis_d;

    logic              misalign_c;
    logic              acc_c;
    logic              wb_bubble_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   ext_c;
    logic [XLEN-1:0]   mem_data_c;

`ifdef CORE_MEM_MISALIGN_CHK_EN
    assign misalign_c = mem_val_inst_in & mem_l1d_val_in &
                        (((mem_l1d_size_in == SZ_HALF) & mem_addr_in[0]) |
                         ((mem_l1d_size_in == SZ_WORD) & (mem_addr_in[1:0] != 2'b00)));
`else
    assign misalign_c = 1'b0;
`endif

    assign acc_c = mem_val_inst_in & mem_l1d_val_in & ~misalign_c;

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_wrt_data_in;
        case (mem_l1d_size_in)
            SZ_BYTE: begin
                be_c    = 4'b0001 << mem_addr_in[1:0];
                wdata_c = {4{mem_wrt_data_in[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << {mem_addr_in[1], 1'b0};
                wdata_c = {2{mem_wrt_data_in[15:0]}};
            end
            SZ_WORD: begin
                be_c    = 4'b1111;
                wdata_c = mem_wrt_data_in;
            end
            default: ;
        endcase
    end

    // Lane select and extension use the offset/op latched when the request was launched
    always_comb begin
        byte_c = l1d.l1d_ack_rdata[{off_q, 3'b000} +: 8];
        half_c = l1d.l1d_ack_rdata[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            SX_SB:       ext_c = {{24{byte_c[7]}}, byte_c};
            SX_SH:       ext_c = {{16{half_c[15]}}, half_c};
            SX_UB:       ext_c = {24'd0, byte_c};
            SX_UH:       ext_c = {16'd0, half_c};
            SX_W, SX_BP: ext_c = l1d.l1d_ack_rdata;
            default:     ext_c = l1d.l1d_ack_rdata;
        endcase
    end

    // Next-state, stall and mem/wb register update
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        req_cop_d     = req_cop_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_be_d      = req_be_q;
        off_d         = off_q;
        op_d          = op_q;
        buf_d         = buf_q;
        result_d      = result_q;
        rd_d          = rd_q;
        we_d          = we_q;
        val_d         = val_q;
        mis_d         = mis_q;
        mem_stall_out = 1'b0;
        mem_data_c    = ext_c;
        wb_bubble_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_stall_out = acc_c;
                if (acc_c & ~mem_kill) begin
                    state_d     = S_REQ;
                    req_cop_d   = mem_l1d_cop_in;
                    req_addr_d  = {mem_addr_in[31:2], 2'b00};
                    req_wdata_d = wdata_c;
                    req_be_d    = be_c;
                    off_d       = mem_addr_in[1:0];
                    op_d        = mem_wb_sx_op_in;
                end
            end
            S_REQ: begin
                mem_stall_out = 1'b1;
                // An accepted request must still be drained even if killed
                if (l1d.l1d_req_ack) begin
                    state_d = S_WAIT;
                    drop_d  = mem_kill;
                end else if (mem_kill) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                mem_stall_out = ~l1d.l1d_ack_val;
                wb_bubble_c   = drop_q;
                if (mem_kill) drop_d = 1'b1;
                if (l1d.l1d_ack_val) begin
                    drop_d = 1'b0;
                    if (drop_q | mem_kill | mem_enb) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        buf_d   = ext_c;
                    end
                end
            end
            S_DONE: begin
                mem_data_c = buf_q;
                if (mem_kill | mem_enb) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wb_bubble_c = wb_bubble_c | mem_kill | mem_stall_out;
        if (mem_kill | mem_enb) begin
            result_d = mem_mux_alu_mem_in ? mem_data_c : mem_alu_result_in;
            rd_d     = mem_rd_in;
            val_d    = mem_val_inst_in & ~wb_bubble_c;
            we_d     = mem_we_reg_file_in & ~misalign_c & ~wb_bubble_c;
            mis_d    = misalign_c & ~wb_bubble_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            req_cop_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            off_q       <= '0;
            op_q        <= '0;
            buf_q       <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            val_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            req_cop_q   <= req_cop_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            off_q       <= off_d;
            op_q        <= op_d;
            buf_q       <= buf_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            val_q       <= val_d;
            mis_q       <= mis_d;
        end
    end

    assign l1d.l1d_req_val   = (state_q == S_REQ);
    assign l1d.l1d_req_cop   = req_cop_q;
    assign l1d.l1d_req_addr  = req_addr_q;
    assign l1d.l1d_req_wdata = req_wdata_q;
    assign l1d.l1d_req_be    = req_be_q;

    assign mem_result_out_reg      = result_q;
    assign mem2haz_result_out      = result_q;
    assign mem_rd_out_reg          = rd_q;
    assign mem_we_reg_file_out_reg = we_q;
    assign mem_val_inst_out_reg    = val_q;
    assign mem_misalign_out_reg    = mis_q;
endmodule

// File: tb/tb_core_mem_s.sv
// tb_core_mem_s: self-checking bench for core_mem_s with a scripted L1D responder and a mem/wb scoreboard.
module tb_core_mem_s;
    logic        clk;
    logic        rst;
    logic        mem_enb;
    logic        mem_kill;
    logic        mem_val_inst_in;
    logic        mem_we_reg_file_in;
    logic [2:0]  mem_wb_sx_op_in;
    logic        mem_mux_alu_mem_in;
    logic        mem_l1d_val_in;
    logic        mem_l1d_cop_in;
    logic [2:0]  mem_l1d_size_in;
    logic [31:0] mem_alu_result_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wrt_data_in;
    logic [4:0]  mem_rd_in;
    logic        mem_stall_out;
    logic [31:0] mem2haz_result_out;
    logic [31:0] mem_result_out_reg;
    logic [4:0]  mem_rd_out_reg;
    logic        mem_we_reg_file_out_reg;
    logic        mem_val_inst_out_reg;
    logic        mem_misalign_out_reg;

    core_mem_s_if l1d_bus();

    core_mem_s dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_enb                 (mem_enb),
        .mem_kill                (mem_kill),
        .mem_val_inst_in         (mem_val_inst_in),
        .mem_we_reg_file_in      (mem_we_reg_file_in),
        .mem_wb_sx_op_in         (mem_wb_sx_op_in),
        .mem_mux_alu_mem_in      (mem_mux_alu_mem_in),
        .mem_l1d_val_in          (mem_l1d_val_in),
        .mem_l1d_cop_in          (mem_l1d_cop_in),
        .mem_l1d_size_in         (mem_l1d_size_in),
        .mem_alu_result_in       (mem_alu_result_in),
        .mem_addr_in             (mem_addr_in),
        .mem_wrt_data_in         (mem_wrt_data_in),
        .mem_rd_in               (mem_rd_in),
        .l1d                     (l1d_bus),
        .mem_stall_out           (mem_stall_out),
        .mem2haz_result_out      (mem2haz_result_out),
        .mem_result_out_reg      (mem_result_out_reg),
        .mem_rd_out_reg          (mem_rd_out_reg),
        .mem_we_reg_file_out_reg (mem_we_reg_file_out_reg),
        .mem_val_inst_out_reg    (mem_val_inst_out_reg),
        .mem_misalign_out_reg    (mem_misalign_out_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        val;
        logic        mis;
        bit          chk_res;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scripted L1D: accept in the first REQ cycle, respond ack_delay cycles later
    int          ack_delay  = 1;
    logic [31:0] rdata_next = '0;
    int          req_cnt    = 0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be    = '0;
    logic        last_cop   = 1'b0;
    bit          busy       = 1'b0;
    int          wait_cnt   = 0;

    initial begin
        l1d_bus.l1d_req_ack   = 1'b0;
        l1d_bus.l1d_ack_val   = 1'b0;
        l1d_bus.l1d_ack_rdata = '0;
        forever begin
            @(negedge clk);
            l1d_bus.l1d_req_ack   = 1'b0;
            l1d_bus.l1d_ack_val   = 1'b0;
            l1d_bus.l1d_ack_rdata = '0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    l1d_bus.l1d_ack_val   = 1'b1;
                    l1d_bus.l1d_ack_rdata = rdata_next;
                    busy = 1'b0;
                end
            end else if (l1d_bus.l1d_req_val) begin
                l1d_bus.l1d_req_ack = 1'b1;
                busy       = 1'b1;
                wait_cnt   = ack_delay;
                req_cnt++;
                last_addr  = l1d_bus.l1d_req_addr;
                last_wdata = l1d_bus.l1d_req_wdata;
                last_be    = l1d_bus.l1d_req_be;
                last_cop   = l1d_bus.l1d_req_cop;
            end
        end
    end

    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] op);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (32'(off) * 8);
        sh = w >> (32'(off[1]) * 16);
        case (op)
            3'd0:    ref_ext = {{24{sb[7]}}, sb[7:0]};
            3'd1:    ref_ext = {{16{sh[15]}}, sh[15:0]};
            3'd3:    ref_ext = {24'd0, sb[7:0]};
            3'd4:    ref_ext = {16'd0, sh[15:0]};
            default: ref_ext = w;
        endcase
    endfunction

    task automatic drive_idle();
        mem_val_inst_in    = 1'b0;
        mem_l1d_val_in     = 1'b0;
        mem_we_reg_file_in = 1'b0;
        mem_kill           = 1'b0;
    endtask

    task automatic drive(input logic l1d, input logic cop, input logic [2:0] size, input logic [2:0] op,
                         input logic mux, input logic we, input logic [31:0] alu, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        mem_val_inst_in    = 1'b1;
        mem_l1d_val_in     = l1d;
        mem_l1d_cop_in     = cop;
        mem_l1d_size_in    = size;
        mem_wb_sx_op_in    = op;
        mem_mux_alu_mem_in = mux;
        mem_we_reg_file_in = we;
        mem_alu_result_in  = alu;
        mem_addr_in        = addr;
        mem_wrt_data_in    = wdata;
        mem_rd_in          = rd;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic we,
                            input logic val, input logic mis, input bit chk_res);
        wb_exp_t e;
        e.res = res; e.rd = rd; e.we = we; e.val = val; e.mis = mis; e.chk_res = chk_res;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until the stage hands the instruction to mem/wb, then score it
    task automatic wait_accept(input string tag, output int stall_cyc);
        int      n;
        bit      ok;
        wb_exp_t e;
        n = 0; ok = 1'b0; stall_cyc = 0;
        while (!ok && n < 40) begin
            @(negedge clk); #1;
            if (mem_stall_out) stall_cyc++;
            if (mem_enb && !mem_stall_out) ok = 1'b1;
            n++;
        end
        chk_eq({tag, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        chk_eq({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk_res) begin
                chk_eq({tag, "_res"}, mem_result_out_reg, e.res);
                chk_eq({tag, "_haz"}, mem2haz_result_out, e.res);
            end
            chk_eq({tag, "_rd"},  32'(mem_rd_out_reg), 32'(e.rd));
            chk_eq({tag, "_we"},  32'(mem_we_reg_file_out_reg), 32'(e.we));
            chk_eq({tag, "_val"}, 32'(mem_val_inst_out_reg), 32'(e.val));
            chk_eq({tag, "_mis"}, 32'(mem_misalign_out_reg), 32'(e.mis));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          sc;
        int          s01;
        int          s24;
        int          rc;
        logic [1:0]  off;
        logic [2:0]  op;
        logic [31:0] w;

        rst = 1'b1; mem_enb = 1'b1;
        drive_idle();
        drive(1'b0, 1'b0, 3'b100, 3'd2, 1'b0, 1'b0, '0, '0, '0, '0);
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_res",   mem_result_out_reg, 32'h0);
        chk_eq("rst_rd",    32'(mem_rd_out_reg), 32'h0);
        chk_eq("rst_we",    32'(mem_we_reg_file_out_reg), 32'h0);
        chk_eq("rst_val",   32'(mem_val_inst_out_reg), 32'h0);
        chk_eq("rst_mis",   32'(mem_misalign_out_reg), 32'h0);
        chk_eq("rst_stall", 32'(mem_stall_out), 32'h0);
        chk_eq("rst_req",   32'(l1d_bus.l1d_req_val), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Non-memory instruction: single cycle, no stall
        drive(1'b0, 1'b0, 3'b100, 3'd2, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 5'd7);
        push_exp(32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("alu", sc);
        chk_eq("alu_stall", 32'(sc), 32'd0);

        // LW 0x100
        rdata_next = 32'hDEAD_BEEF; ack_delay = 1;
        drive(1'b1, 1'b0, 3'b100, 3'd2, 1'b1, 1'b1, 32'h0, 32'h100, 32'h0, 5'd5);
        push_exp(32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("lw", sc);
        chk_eq("lw_stall", 32'(sc), 32'd2);
        chk_eq("lw_addr",  last_addr, 32'h100);
        chk_eq("lw_be",    32'(last_be), 32'hF);
        chk_eq("lw_cop",   32'(last_cop), 32'h0);

        // LB / LBU at 0x103
        rdata_next = 32'h80FF_FFFF;
        drive(1'b1, 1'b0, 3'b001, 3'd0, 1'b1, 1'b1, 32'h0, 32'h103, 32'h0, 5'd6);
        push_exp(32'hFFFF_FF80, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("lb", sc);
        chk_eq("lb_be", 32'(last_be), 32'h8);
        drive(1'b1, 1'b0, 3'b001, 3'd3, 1'b1, 1'b1, 32'h0, 32'h103, 32'h0, 5'd6);
        push_exp(32'h0000_0080, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("lbu", sc);

        // LH / LHU at both halves
        rdata_next = 32'h8001_7FFE;
        for (int i = 0; i < 4; i++) begin
            off = (i % 2 == 1) ? 2'd2 : 2'd0;
            op  = (i < 2) ? 3'd1 : 3'd4;
            drive(1'b1, 1'b0, 3'b010, op, 1'b1, 1'b1, 32'h0, 32'h400 + 32'(off), 32'h0, 5'(10 + i));
            push_exp(ref_ext(rdata_next, off, op), 5'(10 + i), 1'b1, 1'b1, 1'b0, 1'b1);
            wait_accept("lh", sc);
        end

        // Pass-through op returns the raw word
        rdata_next = 32'h0BAD_F00D;
        drive(1'b1, 1'b0, 3'b100, 3'd5, 1'b1, 1'b1, 32'h0, 32'h104, 32'h0, 5'd20);
        w = rdata_next;
        push_exp(w, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("bp", sc);

        // SH 0x102: lane replication and upper-half enables
        drive(1'b1, 1'b1, 3'b010, 3'd2, 1'b0, 1'b0, 32'h102, 32'h102, 32'h0000_1234, 5'd8);
        push_exp(32'h102, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_accept("sh", sc);
        chk_eq("sh_stall", 32'(sc), 32'd2);
        chk_eq("sh_be",    32'(last_be), 32'hC);
        chk_eq("sh_wdata", last_wdata, 32'h1234_1234);
        chk_eq("sh_addr",  last_addr, 32'h100);
        chk_eq("sh_cop",   32'(last_cop), 32'h1);

        // Ack while mem_enb low: data parked, stall released, loads when enb rises
        mem_enb = 1'b0; rdata_next = 32'hCAFE_F00D; rc = req_cnt;
        drive(1'b1, 1'b0, 3'b100, 3'd2, 1'b1, 1'b1, 32'h0, 32'h200, 32'h0, 5'd12);
        push_exp(32'hCAFE_F00D, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
        s01 = 0; s24 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (k < 2) s01 += 32'(mem_stall_out);
            else       s24 += 32'(mem_stall_out);
            if (k < 4) begin
                @(posedge clk); #1;
            end
        end
        chk_eq("done_stall_hi", 32'(s01), 32'd2);
        chk_eq("done_stall_lo", 32'(s24), 32'd0);
        @(posedge clk); #1;
        chk_eq("done_hold_rd", 32'(mem_rd_out_reg), 32'd8);
        mem_enb = 1'b1;
        wait_accept("done", sc);
        chk_eq("done_reqs", 32'(req_cnt - rc), 32'd1);

        // Kill in WAIT, ack two cycles later: stall held, response discarded
        ack_delay = 3; rdata_next = 32'h1111_1111; rc = req_cnt;
        drive(1'b1, 1'b0, 3'b100, 3'd2, 1'b1, 1'b1, 32'h0, 32'h300, 32'h0, 5'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_kill = 1'b1;
        @(posedge clk); #1;
        mem_kill = 1'b0;
        chk_eq("kill_val0", 32'(mem_val_inst_out_reg), 32'h0);
        chk_eq("kill_we0",  32'(mem_we_reg_file_out_reg), 32'h0);
        @(negedge clk); #1;
        chk_eq("kill_stall_held", 32'(mem_stall_out), 32'h1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk_eq("kill_stall_rel", 32'(mem_stall_out), 32'h0);
        @(posedge clk); #1;
        drive_idle();
        chk_eq("kill_val", 32'(mem_val_inst_out_reg), 32'h0);
        chk_eq("kill_we",  32'(mem_we_reg_file_out_reg), 32'h0);
        chk_eq("kill_reqs", 32'(req_cnt - rc), 32'd1);

        // Recovery: normal load after the discarded one
        ack_delay = 1; rdata_next = 32'h2222_3333;
        drive(1'b1, 1'b0, 3'b100, 3'd2, 1'b1, 1'b1, 32'h0, 32'h304, 32'h0, 5'd14);
        push_exp(32'h2222_3333, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("recov", sc);
        chk_eq("recov_addr", last_addr, 32'h304);

        // LW at 0x101
        rc = req_cnt; rdata_next = 32'hA5A5_A5A5;
        drive(1'b1, 1'b0, 3'b100, 3'd2, 1'b1, 1'b1, 32'h0, 32'h101, 32'h0, 5'd3);
`ifdef CORE_MEM_MISALIGN_CHK_EN
        push_exp(32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_accept("mis", sc);
        chk_eq("mis_stall", 32'(sc), 32'd0);
        chk_eq("mis_noreq", 32'(req_cnt - rc), 32'd0);
`else
        push_exp(32'hA5A5_A5A5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_accept("mis", sc);
        chk_eq("mis_stall", 32'(sc), 32'd2);
        chk_eq("mis_addr",  last_addr, 32'h100);
        chk_eq("mis_be",    32'(last_be), 32'hF);
        chk_eq("mis_reqs",  32'(req_cnt - rc), 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
